// File: rtl/cpu_control.sv
// Instruction register and sequencing FSM for a small 16-bit datapath CPU.
// All control outputs are Moore outputs, decoded from the FSM state and the IR.
//
//   state     | meaning
//   ----------+---------------------------------------------------------
//   WAIT      | idle, w=1; IR may be loaded, s starts an instruction
//   DECODE    | classify opcode/op, choose the execution path
//   GET_A     | read Rn into the A register
//   GET_B     | read Rm into the B register
//   CALC      | run the ALU; result to C, or status flags for CMP
//   WRITE_REG | write C back to Rd
//   WRITE_IMM | write sign-extended imm8 to Rn
module cpu_control (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s,
    input  logic        load,
    input  logic [15:0] in,
    output logic        w,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic [3:0]  vsel,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic        shiftavoid,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5
);

    typedef enum logic [2:0] {
        ST_WAIT      = 3'd0,
        ST_DECODE    = 3'd1,
        ST_GET_A     = 3'd2,
        ST_GET_B     = 3'd3,
        ST_CALC      = 3'd4,
        ST_WRITE_REG = 3'd5,
        ST_WRITE_IMM = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] ir;

    logic [2:0] opcode;
    logic [1:0] op;
    logic [2:0] rn, rd, rm;

    assign opcode = ir[15:13];
    assign op     = ir[12:11];
    assign rn     = ir[10:8];
    assign rd     = ir[7:5];
    assign rm     = ir[2:0];

    logic is_mov_imm, is_mov_reg, is_alu, is_cmp, is_mvn;

    assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
    assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu     = (opcode == 3'b101);
    assign is_cmp     = is_alu && (op == 2'b01);
    assign is_mvn     = is_alu && (op == 2'b11);

    // Immediates and shifter control follow the IR continuously.
    assign sximm8 = {{8{ir[7]}}, ir[7:0]};
    assign sximm5 = {{11{ir[4]}}, ir[4:0]};
    assign shift  = ir[4:3];

    // IR capture: only while idle, so the IR is stable for a whole instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ir <= 16'h0000;
        else if (state == ST_WAIT && load)
            ir <= in;
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            state <= ST_WAIT;
        else
            state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT:      state_nxt = s ? ST_DECODE : ST_WAIT;
            ST_DECODE: begin
                if (is_mov_imm)
                    state_nxt = ST_WRITE_IMM;
                else if (is_mov_reg || is_mvn)
                    state_nxt = ST_GET_B;
                else if (is_alu)
                    state_nxt = ST_GET_A;
                else
                    state_nxt = ST_WAIT;
            end
            ST_GET_A:     state_nxt = ST_GET_B;
            ST_GET_B:     state_nxt = ST_CALC;
            ST_CALC:      state_nxt = is_cmp ? ST_WAIT : ST_WRITE_REG;
            ST_WRITE_REG: state_nxt = ST_WAIT;
            ST_WRITE_IMM: state_nxt = ST_WAIT;
            default:      state_nxt = ST_WAIT;
        endcase
    end

    // Output decode from state and IR.
    always_comb begin
        w          = 1'b0;
        readnum    = rn;
        writenum   = rd;
        write      = 1'b0;
        vsel       = 4'b0000;
        loada      = 1'b0;
        loadb      = 1'b0;
        loadc      = 1'b0;
        loads      = 1'b0;
        asel       = 1'b0;
        bsel       = 1'b0;
        shiftavoid = 1'b0;
        ALUop      = 2'b00;
        case (state)
            ST_WAIT:   w = 1'b1;
            ST_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
            end
            ST_GET_B: begin
                readnum = rm;
                loadb   = 1'b1;
            end
            ST_CALC: begin
                // MOV reg passes B through an ADD with A forced to zero.
                if (is_mov_reg) begin
                    ALUop = 2'b00;
                    asel  = 1'b1;
                end else begin
                    ALUop = op;
                    asel  = 1'b0;
                end
                if (is_cmp)
                    loads = 1'b1;
                else
                    loadc = 1'b1;
            end
            ST_WRITE_REG: begin
                writenum = rd;
                vsel     = 4'b1000;
                write    = 1'b1;
            end
            ST_WRITE_IMM: begin
                writenum = rn;
                vsel     = 4'b0010;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
